axis_fork_n: RTL and testbench
==============================

AXIS_FORK_N -- requirements
Module: axis_fork_n

Interface
REQ-001 SHALL have parameter DATA_WD, default 64: tdata width in bits.
REQ-002 SHALL have parameter NUM_M, default 4, legal range 2..8: number of master ports.
REQ-003 SHALL have parameter RR_ON_LAST, default 0: 0 advances the round-robin pointer per beat, 1 advances it per packet (beat with tlast=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mode, input, 2 bits: 0 round-robin, 1 broadcast, 2 select, 3 drop.
REQ-007 SHALL have port sel, input, 3 bits: destination index used in select mode.
REQ-008 SHALL have ports s_axis_tvalid (input, 1), s_axis_tdata (input, DATA_WD), s_axis_tlast (input, 1) and s_axis_tready (output, 1).
REQ-009 SHALL have ports m_axis_tvalid (output, NUM_M), m_axis_tdata (output, NUM_M*DATA_WD, port i at bits [i*DATA_WD +: DATA_WD]), m_axis_tlast (output, NUM_M) and m_axis_tready (input, NUM_M).
REQ-010 SHALL have port rr_ptr, output, 3 bits: current round-robin index.
REQ-011 SHALL have port err_sel, output, 1 bit: one-cycle pulse when a select-mode beat carries sel >= NUM_M.

Function
REQ-012 SHALL hold one beat in a register stage (valid_reg, data_reg, last_reg, tgt[NUM_M], done[NUM_M]), giving 1-cycle latency from input handshake to output tvalid.
REQ-013 SHALL sample mode and sel per beat at the input handshake; changes while a beat is held do not affect that beat.
REQ-014 SHALL compute tgt at acceptance as follows: mode 0 gives one-hot(rr_ptr); mode 1 gives all ones; mode 2 gives one-hot(sel) if sel < NUM_M, else zero; mode 3 gives zero.
REQ-015 SHALL discard a beat accepted with tgt == 0: valid_reg is loaded with 0 and the beat never appears on any output.
REQ-016 SHALL assert err_sel for exactly the cycle after a mode-2 acceptance with sel >= NUM_M, and hold it 0 otherwise.
REQ-017 SHALL drive m_axis_tvalid[i] = valid_reg & tgt[i] & !done[i].
REQ-018 SHALL drive m_axis_tdata for every port with data_reg, and m_axis_tlast[i] with last_reg.
REQ-019 SHALL set done[i] on every handshake of port i that does not complete the beat.
REQ-020 SHALL treat the beat as complete in the cycle where (done | (m_axis_tvalid & m_axis_tready)) == tgt.
REQ-021 SHALL clear done on completion.
REQ-022 SHALL drive s_axis_tready = !valid_reg | complete; a new beat loads in the same cycle the old one completes, so a full-throughput stream sustains 1 beat/cycle.
REQ-023 SHALL compute s_axis_tready without any combinational path from s_axis_tvalid.
REQ-024 SHALL in broadcast mode let each port handshake independently, in any cycle order; a port already done sees tvalid=0 until the next beat.
REQ-025 SHALL in mode 0 advance rr_ptr at input acceptance (every beat if RR_ON_LAST=0; only on tlast=1 beats if RR_ON_LAST=1), wrapping from NUM_M-1 to 0.
REQ-026 SHALL leave rr_ptr unchanged in modes 1, 2 and 3, with no reset on mode change.
REQ-027 SHALL keep data_reg, last_reg and tgt stable while valid_reg=1 and the beat is not complete (AXIS stability).

Reset
REQ-028 SHALL, while rst_n=0 (asynchronous assert, synchronous-release use assumed by integration), force valid_reg=0, done=0, tgt=0, data_reg=0, last_reg=0, rr_ptr=0 and err_sel=0.
REQ-029 SHALL therefore hold all m_axis_tvalid=0 and s_axis_tready=1 in reset; reset mid-beat discards the held beat with no partial broadcast completion retained.

Verification
REQ-030 The bench SHALL cover round-robin: NUM_M=4, mode 0, RR_ON_LAST=0, all tready=1, beats D0..D5 back-to-back -> D0,D4 on m0, D1,D5 on m1, D2 on m2, D3 on m3, 1 beat/cycle, rr_ptr=2 at end.
REQ-031 The bench SHALL cover packet round-robin: RR_ON_LAST=1, two 3-beat packets -> packet 1 entirely on m0, packet 2 on m1, rr_ptr=2.
REQ-032 The bench SHALL cover broadcast backpressure: mode 1, beat 0xA5, m2 tready=0 for 3 cycles, others 1 -> m0, m1, m3 take 0xA5 once in cycle 1, m2 takes it in cycle 4, s_axis_tready=0 in cycles 2-3 and 1 in cycle 4.
REQ-033 The bench SHALL cover select error: NUM_M=4, mode 2, sel=5, one beat -> no m tvalid, err_sel=1 for one cycle, s_axis_tready stays 1.
REQ-034 The bench SHALL cover drop mode: mode 3, 10 beats -> all accepted at 1/cycle, no outputs, rr_ptr unchanged.
REQ-035 The bench SHALL cover reset mid-broadcast: mode 1, m1 done, m0 pending, rst_n pulsed low -> all tvalid=0 immediately; after release s_axis_tready=1 and the next beat goes to all ports.

Source files
------------

// File: rtl/axis_fork_n.sv
// AXI-Stream 1-to-N fork with a single-beat holding register.
// Beats are routed round-robin, broadcast, to a selected port, or dropped.
module axis_fork_n #(
   parameter int DATA_WD    = 64,
   parameter int NUM_M      = 4,
   parameter bit RR_ON_LAST = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               mode,
   input  logic [2:0]               sel,
   input  logic                     s_axis_tvalid,
   input  logic [DATA_WD-1:0]       s_axis_tdata,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [NUM_M-1:0]         m_axis_tvalid,
   output logic [NUM_M*DATA_WD-1:0] m_axis_tdata,
   output logic [NUM_M-1:0]         m_axis_tlast,
   input  logic [NUM_M-1:0]         m_axis_tready,
   output logic [2:0]               rr_ptr,
   output logic                     err_sel
);

   localparam logic [1:0] MODE_RR   = 2'd0;
   localparam logic [1:0] MODE_BC   = 2'd1;
   localparam logic [1:0] MODE_SEL  = 2'd2;
   localparam logic [2:0] RR_LAST   = 3'(NUM_M - 1);

   logic               valid_reg;
   logic               last_reg;
   logic [DATA_WD-1:0] data_reg;
   logic [NUM_M-1:0]   tgt;
   logic [NUM_M-1:0]   done;
   logic [NUM_M-1:0]   tgt_nxt;
   logic [NUM_M-1:0]   hs;
   logic [NUM_M-1:0]   got;
   logic               complete;
   logic               accept;
   logic               rr_step;
   logic               sel_bad;

   assign m_axis_tvalid = {NUM_M{valid_reg}} & tgt & ~done;
   assign m_axis_tdata  = {NUM_M{data_reg}};
   assign m_axis_tlast  = {NUM_M{last_reg}};

   // got: ports served so far including this cycle's handshakes
   assign hs       = m_axis_tvalid & m_axis_tready;
   assign got      = done | hs;
   assign complete = valid_reg && (got == tgt);

   assign s_axis_tready = !valid_reg || complete;
   assign accept        = s_axis_tvalid && s_axis_tready;

   assign sel_bad = 32'(sel) >= NUM_M;
   assign rr_step = accept && (mode == MODE_RR) &&
                    (!RR_ON_LAST || s_axis_tlast);

   always_comb begin
      tgt_nxt = '0;
      for (int i = 0; i < NUM_M; i++) begin
         unique case (mode)
            MODE_RR:  tgt_nxt[i] = (rr_ptr == 3'(i));
            MODE_BC:  tgt_nxt[i] = 1'b1;
            MODE_SEL: tgt_nxt[i] = (sel == 3'(i));
            default:  tgt_nxt[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         data_reg  <= '0;
         tgt       <= '0;
         done      <= '0;
         rr_ptr    <= 3'd0;
         err_sel   <= 1'b0;
      end else begin
         err_sel <= accept && (mode == MODE_SEL) && sel_bad;
         if (rr_step)
            rr_ptr <= (rr_ptr == RR_LAST) ? 3'd0 : rr_ptr + 3'd1;
         // an all-zero target leaves the stage empty, dropping the beat
         if (accept) begin
            valid_reg <= |tgt_nxt;
            data_reg  <= s_axis_tdata;
            last_reg  <= s_axis_tlast;
            tgt       <= tgt_nxt;
            done      <= '0;
         end else if (complete) begin
            valid_reg <= 1'b0;
            done      <= '0;
         end else if (valid_reg) begin
            done <= got;
         end
      end
   end

endmodule

// File: tb/tb_axis_fork_n.sv
// Directed bench for axis_fork_n: per-beat and per-packet instances
// share stimulus; a per-port scoreboard checks every output handshake.
module tb_axis_fork_n;

   localparam int DW = 32;
   localparam int NM = 4;

   typedef logic [DW:0] ent_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      mode = 2'd0;
   logic [2:0]      sel = 3'd0;
   logic            s_tvalid = 1'b0;
   logic [DW-1:0]   s_tdata = '0;
   logic            s_tlast = 1'b0;
   logic [NM-1:0]   m_tready = '1;

   logic            s_tready0, s_tready1;
   logic [NM-1:0]   m_tvalid0, m_tvalid1;
   logic [NM*DW-1:0] m_tdata0, m_tdata1;
   logic [NM-1:0]   m_tlast0, m_tlast1;
   logic [2:0]      rr0, rr1;
   logic            err0, err1;

   int total = 0;
   int bad = 0;
   int mrr0 = 0;
   int mrr1 = 0;
   ent_t q0 [NM][$];
   ent_t q1 [NM][$];

   always #5 clk = ~clk;

   axis_fork_n #(.DATA_WD(DW), .NUM_M(NM), .RR_ON_LAST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready0),
      .m_axis_tvalid(m_tvalid0), .m_axis_tdata(m_tdata0),
      .m_axis_tlast(m_tlast0), .m_axis_tready(m_tready),
      .rr_ptr(rr0), .err_sel(err0)
   );

   axis_fork_n #(.DATA_WD(DW), .NUM_M(NM), .RR_ON_LAST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready1),
      .m_axis_tvalid(m_tvalid1), .m_axis_tdata(m_tdata1),
      .m_axis_tlast(m_tlast1), .m_axis_tready(m_tready),
      .rr_ptr(rr1), .err_sel(err1)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NM-1:0] tgt_of(input logic [1:0] md,
                                            input logic [2:0] s,
                                            input int rr);
      logic [NM-1:0] t;
      t = '0;
      case (md)
         2'd0: t[rr] = 1'b1;
         2'd1: t = '1;
         2'd2: if (int'(s) < NM) t[s] = 1'b1;
         default: t = '0;
      endcase
      return t;
   endfunction

   task automatic push_exp();
      logic [NM-1:0] t0, t1;
      t0 = tgt_of(mode, sel, mrr0);
      t1 = tgt_of(mode, sel, mrr1);
      for (int i = 0; i < NM; i++) begin
         if (t0[i]) q0[i].push_back({s_tlast, s_tdata});
         if (t1[i]) q1[i].push_back({s_tlast, s_tdata});
      end
      if (mode == 2'd0) begin
         mrr0 = (mrr0 + 1) % NM;
         if (s_tlast) mrr1 = (mrr1 + 1) % NM;
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NM; i++) begin
         q0[i].delete();
         q1[i].delete();
      end
      mrr0 = 0;
      mrr1 = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one beat and hold it until accepted, bounded
   task automatic send(input logic [DW-1:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (s_tready0) begin
            push_exp();
            ok = 1'b1;
         end
         step();
      end
      if (!ok) chk("send_timeout", 64'(s_tready0), 64'd1);
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_tvalid = 1'b0;
      flush();
      step();
      step();
      chk("rst_tvalid0", 64'(m_tvalid0), 64'd0);
      chk("rst_tvalid1", 64'(m_tvalid1), 64'd0);
      chk("rst_tready", 64'({s_tready0, s_tready1}), 64'd3);
      chk("rst_rr", 64'({rr0, rr1}), 64'd0);
      chk("rst_err", 64'({err0, err1}), 64'd0);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < NM; i++) begin
         if (m_tvalid0[i] && m_tready[i]) begin
            if (q0[i].size() == 0)
               chk($sformatf("unexp0_m%0d", i), 64'(m_tdata0[i*DW +: DW]), 64'hdead);
            else
               chk($sformatf("data0_m%0d", i),
                   64'({m_tlast0[i], m_tdata0[i*DW +: DW]}),
                   64'(q0[i].pop_front()));
         end
         if (m_tvalid1[i] && m_tready[i]) begin
            if (q1[i].size() == 0)
               chk($sformatf("unexp1_m%0d", i), 64'(m_tdata1[i*DW +: DW]), 64'hdead);
            else
               chk($sformatf("data1_m%0d", i),
                   64'({m_tlast1[i], m_tdata1[i*DW +: DW]}),
                   64'(q1[i].pop_front()));
         end
      end
   end

   initial begin
      #1;
      do_reset();

      // per-beat round-robin, full throughput
      mode = 2'd0;
      m_tready = '1;
      for (int k = 0; k < 6; k++) begin
         chk("rr_tput", 64'(s_tready0), 64'd1);
         send(32'hD000_0000 + DW'(k), 1'b0);
      end
      idle(3);
      chk("rr_ptr_beat", 64'(rr0), 64'd2);
      chk("rr_ptr_pkt_nolast", 64'(rr1), 64'd0);

      // per-packet round-robin
      do_reset();
      for (int k = 0; k < 6; k++)
         send(32'hC000_0000 + DW'(k), (k % 3) == 2);
      idle(3);
      chk("pkt_rr1", 64'(rr1), 64'd2);
      chk("pkt_rr0", 64'(rr0), 64'd2);

      // broadcast with m2 backpressured for 3 cycles
      do_reset();
      mode = 2'd1;
      m_tready = 4'b1011;
      send(32'hA5, 1'b1);
      s_tvalid = 1'b0;
      chk("bc_c1_tvalid", 64'(m_tvalid0), 64'hF);
      chk("bc_c1_tready", 64'(s_tready0), 64'd0);
      step();
      chk("bc_c2_tvalid", 64'(m_tvalid0), 64'h4);
      chk("bc_c2_tready", 64'(s_tready0), 64'd0);
      step();
      chk("bc_c3_tready", 64'(s_tready0), 64'd0);
      step();
      m_tready = 4'b1111;
      #1;
      chk("bc_c4_tvalid", 64'(m_tvalid0), 64'h4);
      chk("bc_c4_tready", 64'(s_tready0), 64'd1);
      step();
      chk("bc_c5_tvalid", 64'(m_tvalid0), 64'h0);

      // select mode: out-of-range then boundary in-range
      do_reset();
      mode = 2'd2;
      sel = 3'd5;
      send(32'h55, 1'b0);
      s_tvalid = 1'b0;
      chk("sel_err_pulse", 64'(err0), 64'd1);
      chk("sel_err_tvalid", 64'(m_tvalid0), 64'd0);
      chk("sel_err_tready", 64'(s_tready0), 64'd1);
      step();
      chk("sel_err_clear", 64'(err0), 64'd0);
      sel = 3'd3;
      send(32'h33, 1'b1);
      sel = 3'd4;
      send(32'h44, 1'b0);
      s_tvalid = 1'b0;
      chk("sel4_err", 64'(err0), 64'd1);
      idle(2);
      chk("sel_rr_hold", 64'(rr0), 64'd0);

      // drop mode keeps rr_ptr and emits nothing
      mode = 2'd0;
      send(32'h11, 1'b1);
      idle(2);
      mode = 2'd3;
      for (int k = 0; k < 10; k++) begin
         chk("drop_tready", 64'(s_tready0), 64'd1);
         chk("drop_tvalid", 64'(m_tvalid0), 64'd0);
         send(32'hE000_0000 + DW'(k), 1'b0);
      end
      idle(2);
      chk("drop_rr", 64'(rr0), 64'd1);

      // reset in the middle of a partially served broadcast
      do_reset();
      mode = 2'd1;
      m_tready = 4'b0010;
      send(32'h5A, 1'b0);
      s_tvalid = 1'b0;
      step();
      chk("mid_tvalid", 64'(m_tvalid0), 64'hD);
      #3;
      rst_n = 1'b0;
      #1;
      flush();
      chk("mid_rst_tvalid", 64'({m_tvalid0, m_tvalid1}), 64'd0);
      chk("mid_rst_tready", 64'(s_tready0), 64'd1);
      step();
      step();
      rst_n = 1'b1;
      m_tready = '1;
      chk("post_rst_tready", 64'(s_tready0), 64'd1);
      send(32'h77, 1'b1);
      s_tvalid = 1'b0;
      chk("post_rst_bc", 64'(m_tvalid0), 64'hF);
      idle(3);

      for (int i = 0; i < NM; i++) begin
         chk($sformatf("left0_m%0d", i), 64'(q0[i].size()), 64'd0);
         chk($sformatf("left1_m%0d", i), 64'(q1[i].size()), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
